encoder_axis_packer: RTL and testbench
======================================

Name: encoder_axis_packer

Overview:
- Transmit-side counterpart of the decoder FIFO: accepts 16-bit encoder samples through a FIFO-style write port and emits them as an 80-bit AXI4-Stream.
- Each beat carries WORDS_PER_BEAT samples; TUSER marks start of frame and TLAST marks end of line.
- Sits between the encoder core and the AXI-Stream link feeding the decoder.

Parameters:
- DEPTH, 128, sample FIFO depth in entries (power of 2).
- DATA_WIDTH, 16, sample width in bits.
- WORDS_PER_BEAT, 5, samples per beat; TDATA width = DATA_WIDTH*WORDS_PER_BEAT (80).

Ports:
- ACLK  in  1  clock, all logic on rising edge.
- ARESET_N  in  1  reset; synchronous, active-low.
- WR_EN  in  1  write strobe for DATA_IN/SOF_IN/LAST_IN.
- DATA_IN  in  DATA_WIDTH  sample.
- SOF_IN  in  1  sample is first of a frame.
- LAST_IN  in  1  sample is last of a line.
- FULL  out  1  FIFO holds DEPTH entries.
- OVERFLOW  out  1  sticky: a write was dropped.
- TDATA  out  DATA_WIDTH*WORDS_PER_BEAT  stream data; sample lane k at bits [16k+15:16k].
- TVALID  out  1  beat valid.
- TREADY  in  1  sink ready.
- TUSER  out  1  start-of-frame beat.
- TLAST  out  1  end-of-line beat.

Behaviour:
- Reset (ARESET_N=0 at a rising edge):
  - FIFO, assembler and output register are cleared.
  - TVALID, TUSER, TLAST, FULL and OVERFLOW are 0; TDATA is 0.
  - Reset asserted mid-beat discards any partial or held beat; TVALID is 0 from the next cycle.
- FIFO:
  - First-word-fall-through storage of {SOF, LAST, DATA}, DEPTH entries.
  - A write is accepted when WR_EN=1 and FULL=0.
  - WR_EN=1 while FULL=1 drops the sample and sets OVERFLOW, which clears only on reset. This holds even if a pop occurs in the same cycle.
  - FULL is derived from the registered count.
- Assembler:
  - Pops one sample per cycle when the FIFO is non-empty and the assembly register is not holding a completed beat.
  - Lane index runs from 0 to WORDS_PER_BEAT-1; the sample goes into the current lane.
- Beat completion; a beat completes when any of the following occurs:
  - Lane WORDS_PER_BEAT-1 is filled.
  - A sample with LAST_IN is packed: the beat closes at that lane, unused upper lanes are zero, and TLAST=1.
  - A sample with SOF_IN arrives while lane index is not 0: the current partial beat closes first, zero-padded with TLAST=0. The SOF sample is not popped that cycle and starts the next beat at lane 0.
- TUSER:
  - Is 1 on a beat whose lane-0 sample carried SOF_IN.
  - Is also 1 on the first beat after reset, regardless of SOF_IN.
- Output stage:
  - Holds one registered beat.
  - A completed beat moves into the output register when it is empty or when TVALID&&TREADY in the same cycle, which gives full throughput of 1 beat/cycle after fill.
  - While TVALID=1 and TREADY=0, TDATA/TUSER/TLAST stay stable and TVALID does not drop.
  - The assembler keeps filling the next beat and then stalls.
- Latency:
  - Sample written at cycle N is poppable at N+1.
  - TVALID rises 2 cycles after the write cycle of a beat's final sample, provided no backpressure.
- States:
  - FILL: lanes accumulating.
  - READY: beat complete, waiting for the output register.
  - READY moves to FILL when the beat transfers to the output register.
- Capacity under TREADY=0: DEPTH + 2*WORDS_PER_BEAT samples before writes drop.
- Simultaneous SOF_IN and LAST_IN on one sample: a single-lane beat with TUSER=1 and TLAST=1.

Optional Feature:
- Macro PACKER_KEEP_EN.
- Defined: adds output TKEEP of width DATA_WIDTH*WORDS_PER_BEAT/8 (10 bits).
  - Each filled lane sets its 2 byte bits; a full beat is all ones, and a 3-lane beat gives TKEEP=10'h03F.
  - Reset value is 0, and TKEEP holds stable with TDATA.
- Undefined: no TKEEP port. The sink relies on TLAST plus zero padding.

Test Plan:
- After reset, write 0x0001..0x0005 with SOF on the first, TREADY=1 -> one beat with TDATA=80'h0005_0004_0003_0002_0001, TUSER=1, TLAST=0.
- Write 3 samples 0xA1,0xA2,0xA3 with LAST on 0xA3 -> TDATA=80'h0000_0000_00A3_00A2_00A1, TLAST=1; with PACKER_KEEP_EN, TKEEP=10'h03F.
- Write 1920 continuous samples with LAST on the 1920th -> 384 beats, TLAST only on beat 384; then SOF on the next sample -> TUSER=1 on beat 385.
- Write 2 samples, then an SOF sample -> first beat padded (lanes 2-4 zero, TLAST=0), and the SOF sample lands in lane 0 of the next beat with TUSER=1.
- TREADY=0, write 140 samples -> FULL=1 at 138 buffered samples and OVERFLOW=1 after the 139th write; TDATA stays stable throughout; TREADY=1 -> 27 full beats drain in order, and FULL drops.
- Assert ARESET_N=0 for one cycle mid-beat with TVALID=1 -> TVALID=0, FULL=0, OVERFLOW=0 the next cycle; the following write of 5 samples produces a beat with TUSER=1.

Source files
------------

// File: rtl/encoder_axis_packer_if.sv
// Bundles the sample write port and the outgoing AXI4-Stream of encoder_axis_packer.
// master is the packer side; slave is the encoder core / stream sink side. TKEEP exists only with PACKER_KEEP_EN.
interface encoder_axis_packer_if #(
  parameter int DATA_WIDTH     = 16,
  parameter int WORDS_PER_BEAT = 5
);
  localparam int TDATA_W = DATA_WIDTH * WORDS_PER_BEAT;

  logic                  WR_EN;
  logic [DATA_WIDTH-1:0] DATA_IN;
  logic                  SOF_IN;
  logic                  LAST_IN;
  logic                  FULL;
  logic                  OVERFLOW;
  logic [TDATA_W-1:0]    TDATA;
  logic                  TVALID;
  logic                  TREADY;
  logic                  TUSER;
  logic                  TLAST;
`ifdef PACKER_KEEP_EN
  logic [TDATA_W/8-1:0]  TKEEP;
`endif

  modport master (
    input  WR_EN, DATA_IN, SOF_IN, LAST_IN, TREADY,
`ifdef PACKER_KEEP_EN
    output TKEEP,
`endif
    output FULL, OVERFLOW, TDATA, TVALID, TUSER, TLAST
  );

  modport slave (
    output WR_EN, DATA_IN, SOF_IN, LAST_IN, TREADY,
`ifdef PACKER_KEEP_EN
    input  TKEEP,
`endif
    input  FULL, OVERFLOW, TDATA, TVALID, TUSER, TLAST
  );
endinterface

// File: rtl/encoder_axis_packer.sv
// Packs 16-bit encoder samples from a FWFT FIFO into multi-lane AXI4-Stream beats (TUSER=SOF, TLAST=end of line).
// Optional macro PACKER_KEEP_EN adds a TKEEP output marking the filled lanes.
module encoder_axis_packer #(
  parameter int DEPTH          = 128,
  parameter int DATA_WIDTH     = 16,
  parameter int WORDS_PER_BEAT = 5
) (
  input  logic                  ACLK,
  input  logic                  ARESET_N,
  encoder_axis_packer_if.master axis
);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int LANE_W  = (WORDS_PER_BEAT > 1) ? $clog2(WORDS_PER_BEAT) : 1;
  localparam int ENTRY_W = DATA_WIDTH + 2;
  localparam int TDATA_W = DATA_WIDTH * WORDS_PER_BEAT;
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(WORDS_PER_BEAT - 1);

  typedef enum logic {FILL, READY} state_t;

  // Sample FIFO: entries are {sof, last, data}
  logic [ENTRY_W-1:0]    mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg, wr_ptr_next, rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]      count_reg, count_next;
  logic                  overflow_reg, overflow_next;
  logic                  full, empty, wr_accept;
  logic                  head_sof, head_last;
  logic [DATA_WIDTH-1:0] head_data;

  // Assembler and output register
  state_t                                   state_reg, state_next;
  logic [LANE_W-1:0]                        lane_reg, lane_next;
  logic [WORDS_PER_BEAT-1:0][DATA_WIDTH-1:0] asm_data_reg, asm_data_next, beat_data;
  logic                                     asm_user_reg, asm_user_next;
  logic                                     asm_last_reg, asm_last_next;
  logic                                     first_reg, first_next;
  logic [TDATA_W-1:0]                       tdata_reg, tdata_next;
  logic                                     tuser_reg, tuser_next;
  logic                                     tlast_reg, tlast_next;
  logic                                     tvalid_reg, tvalid_next;

  logic                      in_fill, sof_split, pop, complete, beat_done, out_free;
  logic                      beat_user, beat_last;
  logic [WORDS_PER_BEAT-1:0] lane_hit;

  assign full      = (count_reg == DEPTH_CNT);
  assign empty     = (count_reg == '0);
  assign wr_accept = axis.WR_EN && !full;
  // Combinational head read so a sample written in cycle N can be popped in N+1.
  assign {head_sof, head_last, head_data} = mem[rd_ptr_reg];

  always_ff @(posedge ACLK) begin
    if (wr_accept)
      mem[wr_ptr_reg] <= {axis.SOF_IN, axis.LAST_IN, axis.DATA_IN};
  end

  assign in_fill   = (state_reg == FILL);
  // An SOF sample arriving mid-beat closes the partial beat and waits to become lane 0.
  assign sof_split = in_fill && !empty && head_sof && (lane_reg != '0);
  assign pop       = in_fill && !empty && !sof_split;
  assign complete  = sof_split || (pop && (head_last || lane_reg == LAST_LANE));
  assign beat_done = !in_fill || complete;
  assign out_free  = !tvalid_reg || axis.TREADY;
  assign beat_user = in_fill ? (first_reg || ((lane_reg == '0) ? head_sof : asm_user_reg))
                             : asm_user_reg;
  assign beat_last = in_fill ? (pop && head_last) : asm_last_reg;

  genvar gi;
  generate
    for (gi = 0; gi < WORDS_PER_BEAT; gi++) begin : g_lane
      assign lane_hit[gi]  = pop && (lane_reg == LANE_W'(gi));
      assign beat_data[gi] = lane_hit[gi] ? head_data : asm_data_reg[gi];
    end
  endgenerate

  always_comb begin
    wr_ptr_next   = wr_ptr_reg + PTR_W'(wr_accept);
    rd_ptr_next   = rd_ptr_reg + PTR_W'(pop);
    count_next    = count_reg + CNT_W'(wr_accept) - CNT_W'(pop);
    overflow_next = overflow_reg || (axis.WR_EN && full);

    state_next    = state_reg;
    lane_next     = lane_reg;
    asm_data_next = asm_data_reg;
    asm_user_next = asm_user_reg;
    asm_last_next = asm_last_reg;
    first_next    = first_reg;
    tdata_next    = tdata_reg;
    tuser_next    = tuser_reg;
    tlast_next    = tlast_reg;
    tvalid_next   = tvalid_reg && !axis.TREADY;

    if (beat_done) begin
      if (out_free) begin
        // Completed beat goes straight to the output, saving a cycle of latency.
        tdata_next    = beat_data;
        tuser_next    = beat_user;
        tlast_next    = beat_last;
        tvalid_next   = 1'b1;
        state_next    = FILL;
        lane_next     = '0;
        asm_data_next = '0;
        asm_user_next = 1'b0;
        asm_last_next = 1'b0;
      end else begin
        state_next    = READY;
        asm_data_next = beat_data;
        asm_user_next = beat_user;
        asm_last_next = beat_last;
      end
      if (in_fill)
        first_next = 1'b0;
    end else if (pop) begin
      asm_data_next = beat_data;
      lane_next     = lane_reg + 1'b1;
      if (lane_reg == '0)
        asm_user_next = head_sof;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESET_N) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      state_reg    <= FILL;
      lane_reg     <= '0;
      asm_data_reg <= '0;
      asm_user_reg <= 1'b0;
      asm_last_reg <= 1'b0;
      first_reg    <= 1'b1;
      tdata_reg    <= '0;
      tuser_reg    <= 1'b0;
      tlast_reg    <= 1'b0;
      tvalid_reg   <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
      state_reg    <= state_next;
      lane_reg     <= lane_next;
      asm_data_reg <= asm_data_next;
      asm_user_reg <= asm_user_next;
      asm_last_reg <= asm_last_next;
      first_reg    <= first_next;
      tdata_reg    <= tdata_next;
      tuser_reg    <= tuser_next;
      tlast_reg    <= tlast_next;
      tvalid_reg   <= tvalid_next;
    end
  end

  assign axis.FULL     = full;
  assign axis.OVERFLOW = overflow_reg;
  assign axis.TDATA    = tdata_reg;
  assign axis.TVALID   = tvalid_reg;
  assign axis.TUSER    = tuser_reg;
  assign axis.TLAST    = tlast_reg;

`ifdef PACKER_KEEP_EN
  localparam int BYTES_PER_LANE = DATA_WIDTH / 8;
  logic [WORDS_PER_BEAT-1:0] asm_mask_reg, asm_mask_next, out_mask_reg, out_mask_next, beat_mask;
  logic [TDATA_W/8-1:0]      keep_vec;

  assign beat_mask = asm_mask_reg | lane_hit;

  always_comb begin
    asm_mask_next = asm_mask_reg;
    out_mask_next = out_mask_reg;
    if (beat_done) begin
      if (out_free) begin
        out_mask_next = beat_mask;
        asm_mask_next = '0;
      end else begin
        asm_mask_next = beat_mask;
      end
    end else if (pop) begin
      asm_mask_next = beat_mask;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESET_N) begin
      asm_mask_reg <= '0;
      out_mask_reg <= '0;
    end else begin
      asm_mask_reg <= asm_mask_next;
      out_mask_reg <= out_mask_next;
    end
  end

  generate
    for (gi = 0; gi < WORDS_PER_BEAT; gi++) begin : g_keep
      assign keep_vec[gi*BYTES_PER_LANE +: BYTES_PER_LANE] = {BYTES_PER_LANE{out_mask_reg[gi]}};
    end
  endgenerate

  assign axis.TKEEP = keep_vec;
`else
  // Without TKEEP the sink finds the end of a short beat from TLAST and the zero padding.
`endif
endmodule

// File: tb/tb_encoder_axis_packer.sv
// Scoreboard bench for encoder_axis_packer: stimulus pushes expected beats, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_encoder_axis_packer;
  localparam int DW    = 16;
  localparam int WPB   = 5;
  localparam int TW    = DW * WPB;
  localparam int DEPTH = 128;

  logic ACLK     = 1'b0;
  logic ARESET_N = 1'b0;
  int tests_run    = 0;
  int tests_failed = 0;
  int beat_no      = 0;

  encoder_axis_packer_if #(.DATA_WIDTH(DW), .WORDS_PER_BEAT(WPB)) bus ();

  encoder_axis_packer #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .WORDS_PER_BEAT(WPB)) dut (
    .ACLK    (ACLK),
    .ARESET_N(ARESET_N),
    .axis    (bus)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [TW-1:0]   data;
    logic            user;
    logic            last;
    logic [TW/8-1:0] keep;
  } beat_t;

  beat_t exp_q[$];

  task automatic push(input logic [TW-1:0] d, input logic u, input logic l, input logic [TW/8-1:0] k);
    beat_t b;
    b.data = d; b.user = u; b.last = l; b.keep = k;
    exp_q.push_back(b);
  endtask

  task automatic check(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("[TB] %s ok: %0h", name, act);
    end
  endtask

  task automatic wr(input logic [DW-1:0] d, input logic s, input logic l);
    bus.WR_EN   = 1'b1;
    bus.DATA_IN = d;
    bus.SOF_IN  = s;
    bus.LAST_IN = l;
    @(posedge ACLK); #1;
    bus.WR_EN   = 1'b0;
    bus.SOF_IN  = 1'b0;
    bus.LAST_IN = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge ACLK); #1;
      n++;
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL %s_drain: %0d beats outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end else begin
      $display("[TB] %s drained after %0d cycles", name, n);
    end
    repeat (3) @(posedge ACLK);
    #1;
  endtask

  // Monitor: scoreboard compare on every handshake, plus hold-stability under backpressure.
  logic          hold_prev = 1'b0;
  logic [TW-1:0] hold_data;
  logic          hold_user, hold_last;
  always @(negedge ACLK) begin
    beat_t e;
    logic  keep_ok;
    if (!ARESET_N) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        tests_run++;
        if (bus.TVALID !== 1'b1 || bus.TDATA !== hold_data || bus.TUSER !== hold_user || bus.TLAST !== hold_last) begin
          tests_failed++;
          $display("FAIL hold_stable: got valid=%0b data=%0h user=%0b last=%0b, expected valid=1 data=%0h user=%0b last=%0b",
                   bus.TVALID, bus.TDATA, bus.TUSER, bus.TLAST, hold_data, hold_user, hold_last);
        end
      end
      if (bus.TVALID && bus.TREADY) begin
        beat_no++;
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL beat %0d unexpected: data=%0h user=%0b last=%0b", beat_no, bus.TDATA, bus.TUSER, bus.TLAST);
        end else begin
          e = exp_q.pop_front();
`ifdef PACKER_KEEP_EN
          keep_ok = (bus.TKEEP === e.keep);
`else
          keep_ok = 1'b1;
`endif
          if (bus.TDATA !== e.data || bus.TUSER !== e.user || bus.TLAST !== e.last || !keep_ok) begin
            tests_failed++;
            $display("FAIL beat %0d: got data=%0h user=%0b last=%0b, expected data=%0h user=%0b last=%0b keep=%0h",
                     beat_no, bus.TDATA, bus.TUSER, bus.TLAST, e.data, e.user, e.last, e.keep);
          end else begin
            $display("[TB] beat %0d ok data=%0h user=%0b last=%0b", beat_no, bus.TDATA, bus.TUSER, bus.TLAST);
          end
        end
      end
      hold_prev = bus.TVALID && !bus.TREADY;
      hold_data = bus.TDATA;
      hold_user = bus.TUSER;
      hold_last = bus.TLAST;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [TW-1:0] d;
    bus.WR_EN   = 1'b0;
    bus.DATA_IN = '0;
    bus.SOF_IN  = 1'b0;
    bus.LAST_IN = 1'b0;
    bus.TREADY  = 1'b0;

    // Reset state
    ARESET_N = 1'b0;
    repeat (2) @(posedge ACLK);
    #1;
    check("rst_tvalid",   TW'(bus.TVALID),   '0);
    check("rst_tuser",    TW'(bus.TUSER),    '0);
    check("rst_tlast",    TW'(bus.TLAST),    '0);
    check("rst_full",     TW'(bus.FULL),     '0);
    check("rst_overflow", TW'(bus.OVERFLOW), '0);
    check("rst_tdata",    bus.TDATA,         '0);
`ifdef PACKER_KEEP_EN
    check("rst_tkeep",    TW'(bus.TKEEP),    '0);
`endif
    ARESET_N   = 1'b1;
    bus.TREADY = 1'b1;

    // Full beat with SOF, plus write-to-TVALID latency
    push(80'h0005_0004_0003_0002_0001, 1'b1, 1'b0, 10'h3FF);
    wr(16'h0001, 1'b1, 1'b0);
    wr(16'h0002, 1'b0, 1'b0);
    wr(16'h0003, 1'b0, 1'b0);
    wr(16'h0004, 1'b0, 1'b0);
    wr(16'h0005, 1'b0, 1'b0);
    check("lat_before", TW'(bus.TVALID), '0);
    @(posedge ACLK); #1;
    check("lat_rise",   TW'(bus.TVALID), TW'(1));
    wait_drain("full_beat", 20);

    // Short line: three lanes then TLAST
    push(80'h0000_0000_00A3_00A2_00A1, 1'b0, 1'b1, 10'h03F);
    wr(16'h00A1, 1'b0, 1'b0);
    wr(16'h00A2, 1'b0, 1'b0);
    wr(16'h00A3, 1'b0, 1'b1);
    wait_drain("short_line", 20);

    // 1920-sample line with random backpressure, then an SOF+LAST single-lane beat
    for (int b = 0; b < 384; b++) begin
      for (int k = 0; k < WPB; k++) d[k*DW +: DW] = DW'(5*b + k + 1);
      push(d, 1'b0, (b == 383), 10'h3FF);
    end
    push(80'h0000_0000_0000_0000_F000, 1'b1, 1'b1, 10'h003);
    for (int i = 1; i <= 1920; i++) begin
      bus.TREADY = ($urandom_range(0, 3) != 0);
      wr(DW'(i), 1'b0, (i == 1920));
    end
    bus.TREADY = 1'b1;
    wr(16'hF000, 1'b1, 1'b1);
    wait_drain("long_line", 3000);

    // SOF arriving mid-beat splits the partial beat
    push(80'h0000_0000_0000_00B2_00B1, 1'b0, 1'b0, 10'h00F);
    push(80'h00B7_00B6_00B5_00B4_00B3, 1'b1, 1'b0, 10'h3FF);
    wr(16'h00B1, 1'b0, 1'b0);
    wr(16'h00B2, 1'b0, 1'b0);
    wr(16'h00B3, 1'b1, 1'b0);
    wr(16'h00B4, 1'b0, 1'b0);
    wr(16'h00B5, 1'b0, 1'b0);
    wr(16'h00B6, 1'b0, 1'b0);
    wr(16'h00B7, 1'b0, 1'b0);
    wait_drain("sof_split", 30);

    // Backpressure fill: 138 samples fit, the next ones drop
    bus.TREADY = 1'b0;
    for (int b = 0; b < 27; b++) begin
      for (int k = 0; k < WPB; k++) d[k*DW +: DW] = DW'(32'hC000 + 5*b + k);
      push(d, 1'b0, 1'b0, 10'h3FF);
    end
    push(80'hD001_D000_C089_C088_C087, 1'b0, 1'b1, 10'h3FF);
    for (int i = 0; i < 140; i++) begin
      wr(DW'(32'hC000 + i), 1'b0, 1'b0);
      if (i == 136) check("full_at_137", TW'(bus.FULL), '0);
      if (i == 137) begin
        check("full_at_138", TW'(bus.FULL),     TW'(1));
        check("ovf_at_138",  TW'(bus.OVERFLOW), '0);
      end
      if (i == 138) check("ovf_at_139", TW'(bus.OVERFLOW), TW'(1));
    end
    check("bp_head_tdata", bus.TDATA, 80'hC004_C003_C002_C001_C000);
    bus.TREADY = 1'b1;
    repeat (10) @(posedge ACLK);
    #1;
    check("full_drops", TW'(bus.FULL), '0);
    wr(16'hD000, 1'b0, 1'b0);
    wr(16'hD001, 1'b0, 1'b1);
    wait_drain("backpressure", 300);
    check("ovf_sticky", TW'(bus.OVERFLOW), TW'(1));

    // Reset while a beat is held and a partial beat is assembling
    bus.TREADY = 1'b0;
    wr(16'h1111, 1'b0, 1'b0);
    wr(16'h2222, 1'b0, 1'b0);
    wr(16'h3333, 1'b0, 1'b0);
    wr(16'h4444, 1'b0, 1'b0);
    wr(16'h5555, 1'b0, 1'b0);
    wr(16'h6666, 1'b0, 1'b0);
    wr(16'h7777, 1'b0, 1'b0);
    repeat (2) @(posedge ACLK);
    #1;
    check("pre_rst_tvalid", TW'(bus.TVALID), TW'(1));
    ARESET_N = 1'b0;
    @(posedge ACLK); #1;
    ARESET_N = 1'b1;
    check("mid_rst_tvalid",   TW'(bus.TVALID),   '0);
    check("mid_rst_full",     TW'(bus.FULL),     '0);
    check("mid_rst_overflow", TW'(bus.OVERFLOW), '0);
    check("mid_rst_tdata",    bus.TDATA,         '0);
    bus.TREADY = 1'b1;
    push(80'h00E5_00E4_00E3_00E2_00E1, 1'b1, 1'b0, 10'h3FF);
    wr(16'h00E1, 1'b0, 1'b0);
    wr(16'h00E2, 1'b0, 1'b0);
    wr(16'h00E3, 1'b0, 1'b0);
    wr(16'h00E4, 1'b0, 1'b0);
    wr(16'h00E5, 1'b0, 1'b0);
    wait_drain("after_reset", 20);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
